// File: rtl/div_factor_ctrl_if.sv
// Handshake and divider-control bundle for div_factor_ctrl.
// slave  : the controller (accepts requests, drives the divider controls)
// master : the requester / observer side
// With DIV_BYPASS_EN defined the bundle also carries the bypass output.
interface div_factor_ctrl_if #(
    parameter int SIZE = 8
);
    logic            req_valid;
    logic [SIZE-1:0] req_n;
    logic            req_ready;
    logic [SIZE-1:0] div_n;
    logic            div_rst;
    logic            odd_en;
    logic            even_en;
    logic            busy;
    logic            cfg_err;
`ifdef DIV_BYPASS_EN
    logic            bypass;
`endif

    modport slave (
        input  req_valid, req_n,
        output req_ready, div_n, div_rst, odd_en, even_en, busy, cfg_err
`ifdef DIV_BYPASS_EN
        , output bypass
`endif
    );

    modport master (
        output req_valid, req_n,
        input  req_ready, div_n, div_rst, odd_en, even_en, busy, cfg_err
`ifdef DIV_BYPASS_EN
        , input bypass
`endif
    );
endinterface

// File: rtl/div_factor_ctrl.sv
// Upstream control stage for the odd/even clock-divider pair.
// Accepts a divide factor over valid/ready, validates it, and sequences every
// factor change as QUIESCE (enables low) -> LOAD (divider reset, new factor)
// -> RUN, so the divided clock never sees a runt pulse.
// Optional feature macro: DIV_BYPASS_EN (adds bypass output, makes N=1 legal).
module div_factor_ctrl #(
    parameter int SIZE         = 8,
    parameter int QUIET_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    div_factor_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, QUIESCE, LOAD, RUN} state_t;

    localparam int CW = $clog2(QUIET_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(QUIET_CYCLES - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] shadow;
    logic [SIZE-1:0] div_n_q;
    logic            div_rst_q;
    logic            odd_en_q;
    logic            even_en_q;
    logic            busy_q;
    logic            cfg_err_q;
    logic            req_ready_q;
`ifdef DIV_BYPASS_EN
    logic            bypass_q;
`endif

    logic xfer;
    logic req_ok;

    assign xfer = bus.req_valid & req_ready_q;

    // Factor legality; only meaningful when xfer is high.
`ifdef DIV_BYPASS_EN
    assign req_ok = (bus.req_n >= SIZE'(1));
`else
    assign req_ok = (bus.req_n >= SIZE'(2));
`endif

    // Control FSM; every output is a register updated on state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            div_n_q     <= '0;
            div_rst_q   <= 1'b1;
            odd_en_q    <= 1'b0;
            even_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
`ifdef DIV_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            cfg_err_q <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    // IDLE re-asserts ready so it rises right after reset.
                    if (state == IDLE) req_ready_q <= 1'b1;
                    if (xfer) begin
                        if (req_ok) begin
                            shadow      <= bus.req_n;
                            cnt         <= CNT_INIT;
                            state       <= QUIESCE;
                            busy_q      <= 1'b1;
                            req_ready_q <= 1'b0;
                            odd_en_q    <= 1'b0;
                            even_en_q   <= 1'b0;
`ifdef DIV_BYPASS_EN
                            bypass_q    <= 1'b0;
`endif
                        end else begin
                            // Rejected factor: handshake completes, nothing else moves.
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                QUIESCE: begin
                    if (cnt == '0) begin
                        state     <= LOAD;
                        div_n_q   <= shadow;
                        div_rst_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LOAD: begin
                    state       <= RUN;
                    div_rst_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
`ifdef DIV_BYPASS_EN
                    if (div_n_q == SIZE'(1)) begin
                        // Divide-by-one: clock passes through, dividers stay off.
                        bypass_q  <= 1'b1;
                        odd_en_q  <= 1'b0;
                        even_en_q <= 1'b0;
                    end else begin
                        bypass_q  <= 1'b0;
                        odd_en_q  <= div_n_q[0];
                        even_en_q <= ~div_n_q[0];
                    end
`else
                    odd_en_q  <= div_n_q[0];
                    even_en_q <= ~div_n_q[0];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.div_n     = div_n_q;
    assign bus.div_rst   = div_rst_q;
    assign bus.odd_en    = odd_en_q;
    assign bus.even_en   = even_en_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_err   = cfg_err_q;
`ifdef DIV_BYPASS_EN
    assign bus.bypass    = bypass_q;
`endif
endmodule

// File: tb/tb_div_factor_ctrl.sv
// Directed self-checking bench for div_factor_ctrl (SIZE=8, QUIET_CYCLES=4).
// Outputs are sampled 1 time unit after the rising edge.
module tb_div_factor_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    div_factor_ctrl_if #(.SIZE(8)) bus ();

    div_factor_ctrl #(.SIZE(8), .QUIET_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present n for one edge; returns sampling the cycle after the transfer (t+1).
    task automatic send(input logic [7:0] n);
        bus.req_valid = 1'b1;
        bus.req_n     = n;
        tick();
        bus.req_valid = 1'b0;
        bus.req_n     = 8'h00;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_n     = 8'h00;
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.div_rst !== 1'b1)   begin n_bad++; $display("FAIL rst_div_rst got %b want 1", bus.div_rst); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.div_n !== 8'd0)     begin n_bad++; $display("FAIL rst_div_n got %0d want 0", bus.div_n); end
        n_cmp++; if ({bus.odd_en, bus.even_en, bus.busy, bus.cfg_err} !== 4'b0000)
            begin n_bad++; $display("FAIL rst_flags got %b want 0000", {bus.odd_en, bus.even_en, bus.busy, bus.cfg_err}); end
        reset = 1'b0;
        tick();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_req_ready got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.div_rst !== 1'b1)   begin n_bad++; $display("FAIL idle_div_rst got %b want 1", bus.div_rst); end
        n_cmp++; if ({bus.odd_en, bus.even_en} !== 2'b00) begin n_bad++; $display("FAIL idle_en got %b want 00", {bus.odd_en, bus.even_en}); end
    endtask

    task automatic test_load_odd();
        send(8'd5);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL load5_busy t+%0d got %b want 1", k, bus.busy); end
            n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL load5_ready t+%0d got %b want 0", k, bus.req_ready); end
            if (k < 5) tick();
        end
        n_cmp++; if (bus.div_n !== 8'd5)   begin n_bad++; $display("FAIL load5_div_n got %0d want 5", bus.div_n); end
        n_cmp++; if (bus.div_rst !== 1'b1) begin n_bad++; $display("FAIL load5_div_rst got %b want 1", bus.div_rst); end
        tick();
        n_cmp++; if ({bus.div_rst, bus.odd_en, bus.even_en, bus.busy} !== 4'b0100)
            begin n_bad++; $display("FAIL run5 rst/odd/even/busy got %b want 0100", {bus.div_rst, bus.odd_en, bus.even_en, bus.busy}); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL run5_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_change_even();
        send(8'd8);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++; if ({bus.odd_en, bus.even_en} !== 2'b00) begin n_bad++; $display("FAIL chg8_en t+%0d got %b want 00", k, {bus.odd_en, bus.even_en}); end
            if (k < 5) begin
                n_cmp++; if (bus.div_n !== 8'd5) begin n_bad++; $display("FAIL chg8_hold_n t+%0d got %0d want 5", k, bus.div_n); end
            end
            tick();
        end
        n_cmp++; if ({bus.odd_en, bus.even_en} !== 2'b01) begin n_bad++; $display("FAIL run8_en got %b want 01", {bus.odd_en, bus.even_en}); end
        n_cmp++; if (bus.div_n !== 8'd8) begin n_bad++; $display("FAIL run8_div_n got %0d want 8", bus.div_n); end
    endtask

    task automatic test_invalid();
        send(8'd0);
        n_cmp++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL inv0_cfg_err got %b want 1", bus.cfg_err); end
        n_cmp++; if ({bus.div_n, bus.even_en, bus.busy, bus.req_ready} !== {8'd8, 3'b101})
            begin n_bad++; $display("FAIL inv0_state got n=%0d e=%b b=%b r=%b want n=8 e=1 b=0 r=1", bus.div_n, bus.even_en, bus.busy, bus.req_ready); end
        tick();
        n_cmp++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL inv0_pulse got %b want 0", bus.cfg_err); end
`ifndef DIV_BYPASS_EN
        send(8'd1);
        n_cmp++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL inv1_cfg_err got %b want 1", bus.cfg_err); end
        n_cmp++; if ({bus.div_n, bus.even_en, bus.busy, bus.req_ready} !== {8'd8, 3'b101})
            begin n_bad++; $display("FAIL inv1_state got n=%0d e=%b b=%b r=%b want n=8 e=1 b=0 r=1", bus.div_n, bus.even_en, bus.busy, bus.req_ready); end
        tick();
        n_cmp++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL inv1_pulse got %b want 0", bus.cfg_err); end
`endif
    endtask

    task automatic test_same_factor();
        send(8'd8);
        n_cmp++; if ({bus.busy, bus.even_en} !== 2'b10) begin n_bad++; $display("FAIL same8_quiesce busy/even got %b want 10", {bus.busy, bus.even_en}); end
        repeat (5) tick();
        n_cmp++; if ({bus.busy, bus.even_en, bus.div_n} !== {2'b01, 8'd8})
            begin n_bad++; $display("FAIL same8_run got b=%b e=%b n=%0d want b=0 e=1 n=8", bus.busy, bus.even_en, bus.div_n); end
    endtask

    // Request held through QUIESCE/LOAD must stall until RUN.
    task automatic test_back_to_back();
        send(8'd6);
        bus.req_valid = 1'b1;
        bus.req_n     = 8'd9;
        repeat (5) tick();
        n_cmp++; if ({bus.div_n, bus.even_en, bus.req_ready} !== {8'd6, 2'b11})
            begin n_bad++; $display("FAIL b2b_run6 got n=%0d e=%b r=%b want n=6 e=1 r=1", bus.div_n, bus.even_en, bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        bus.req_n     = 8'd0;
        n_cmp++; if ({bus.busy, bus.even_en} !== 2'b10) begin n_bad++; $display("FAIL b2b_accept9 busy/even got %b want 10", {bus.busy, bus.even_en}); end
        repeat (5) tick();
        n_cmp++; if ({bus.div_n, bus.odd_en, bus.even_en} !== {8'd9, 2'b10})
            begin n_bad++; $display("FAIL b2b_run9 got n=%0d o=%b e=%b want n=9 o=1 e=0", bus.div_n, bus.odd_en, bus.even_en); end
    endtask

    task automatic test_boundary();
        send(8'd2);
        n_cmp++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL bnd2_cfg_err got %b want 0", bus.cfg_err); end
        repeat (5) tick();
        n_cmp++; if ({bus.div_n, bus.odd_en, bus.even_en} !== {8'd2, 2'b01})
            begin n_bad++; $display("FAIL bnd2_run got n=%0d o=%b e=%b want n=2 o=0 e=1", bus.div_n, bus.odd_en, bus.even_en); end
        send(8'd255);
        repeat (5) tick();
        n_cmp++; if ({bus.div_n, bus.odd_en, bus.even_en} !== {8'd255, 2'b10})
            begin n_bad++; $display("FAIL bnd255_run got n=%0d o=%b e=%b want n=255 o=1 e=0", bus.div_n, bus.odd_en, bus.even_en); end
    endtask

`ifdef DIV_BYPASS_EN
    task automatic test_bypass();
        n_cmp++; if (bus.bypass !== 1'b0) begin n_bad++; $display("FAIL byp_pre got %b want 0", bus.bypass); end
        send(8'd1);
        n_cmp++; if ({bus.cfg_err, bus.busy} !== 2'b01) begin n_bad++; $display("FAIL byp1_accept err/busy got %b want 01", {bus.cfg_err, bus.busy}); end
        repeat (5) tick();
        n_cmp++; if ({bus.bypass, bus.odd_en, bus.even_en, bus.div_n} !== {3'b100, 8'd1})
            begin n_bad++; $display("FAIL byp1_run got byp=%b o=%b e=%b n=%0d want byp=1 o=0 e=0 n=1", bus.bypass, bus.odd_en, bus.even_en, bus.div_n); end
        send(8'd3);
        n_cmp++; if (bus.bypass !== 1'b0) begin n_bad++; $display("FAIL byp3_clear got %b want 0", bus.bypass); end
        repeat (5) tick();
        n_cmp++; if ({bus.bypass, bus.odd_en} !== 2'b01) begin n_bad++; $display("FAIL byp3_run byp/odd got %b want 01", {bus.bypass, bus.odd_en}); end
    endtask
`endif

    task automatic test_reset_mid();
        send(8'd3);
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if ({bus.div_rst, bus.req_ready, bus.busy, bus.odd_en, bus.even_en, bus.cfg_err} !== 6'b100000)
            begin n_bad++; $display("FAIL mid_rst flags got %b want 100000", {bus.div_rst, bus.req_ready, bus.busy, bus.odd_en, bus.even_en, bus.cfg_err}); end
        n_cmp++; if (bus.div_n !== 8'd0) begin n_bad++; $display("FAIL mid_rst_div_n got %0d want 0", bus.div_n); end
        reset = 1'b0;
        tick();
        n_cmp++; if ({bus.req_ready, bus.busy, bus.div_rst} !== 3'b101)
            begin n_bad++; $display("FAIL mid_idle ready/busy/rst got %b want 101", {bus.req_ready, bus.busy, bus.div_rst}); end
        repeat (6) tick();
        n_cmp++; if ({bus.div_n, bus.div_rst, bus.busy} !== {8'd0, 2'b10})
            begin n_bad++; $display("FAIL mid_no_resume got n=%0d rst=%b busy=%b want n=0 rst=1 busy=0", bus.div_n, bus.div_rst, bus.busy); end
    endtask

    initial begin
        test_reset();
        test_load_odd();
        test_change_even();
        test_invalid();
        test_same_factor();
        test_back_to_back();
        test_boundary();
`ifdef DIV_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
